// File: rtl/cache_request_queue.sv
// Processor-side request queue: buffers read/write requests in a FIFO and issues
// them one at a time to L1, returning a response on completion or on timeout.
module cache_request_queue #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     proc_req_valid,
   input  logic                     proc_req_write,
   input  logic [ADDRESS_WIDTH-1:0] proc_req_address,
   input  logic [DATA_WIDTH-1:0]    proc_req_data,
   output logic                     proc_req_ready,
   output logic                     cache_read_request,
   output logic                     cache_write_request,
   output logic [ADDRESS_WIDTH-1:0] cache_L1_memory_address,
   output logic [DATA_WIDTH-1:0]    cache_write_data,
   input  logic                     L1_cache_ready,
   input  logic                     L1_cache_hit,
   input  logic                     L1_cache_miss,
   input  logic [DATA_WIDTH-1:0]    cache_L1_read_data,
   output logic                     proc_resp_valid,
   output logic [DATA_WIDTH-1:0]    proc_resp_data,
   output logic                     proc_resp_error,
   output logic                     timeout_error,
   output logic [15:0]              hit_count,
   output logic [15:0]              miss_count
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

   state_e                   state_q, state_d;
   logic                     fifoWrite_q [QUEUE_DEPTH];
   logic [ADDRESS_WIDTH-1:0] fifoAddr_q  [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0]    fifoData_q  [QUEUE_DEPTH];
   logic [PTR_W-1:0]         wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     ready_q;
   logic                     inWrite_q;
   logic [ADDRESS_WIDTH-1:0] inAddr_q;
   logic [DATA_WIDTH-1:0]    inData_q;
   logic [TMR_W-1:0]         timer_q, timerInc;
   logic                     respValid_q, respError_q, timeoutErr_q;
   logic [DATA_WIDTH-1:0]    respData_q;
   logic [15:0]              hitCount_q, missCount_q;
   logic                     enq, pop, timerExpired, completeNow, timeoutNow;

   assign enq          = proc_req_valid && ready_q;
   assign pop          = (state_q == IDLE) && (count_q != '0);
   assign timerInc     = timer_q + 1'b1;
   assign timerExpired = (timerInc == TMR_W'(TIMEOUT_CYCLES));
   assign completeNow  = (state_q == WAIT) && L1_cache_ready;
   assign timeoutNow   = (state_q == WAIT) && !L1_cache_ready && timerExpired;

   always_comb begin
      count_d = count_q;
      if (enq && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!enq && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pop) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (completeNow || timeoutNow) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cache_read_request  = 1'b0;
      cache_write_request = 1'b0;
      if (state_q == ISSUE) begin
         cache_read_request  = !inWrite_q;
         cache_write_request = inWrite_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            fifoWrite_q[i] <= 1'b0;
            fifoAddr_q[i]  <= '0;
            fifoData_q[i]  <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else begin
         if (enq) begin
            fifoWrite_q[wrPtr_q] <= proc_req_write;
            fifoAddr_q[wrPtr_q]  <= proc_req_address;
            fifoData_q[wrPtr_q]  <= proc_req_data;
            wrPtr_q              <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
         ready_q <= (count_d < CNT_W'(QUEUE_DEPTH));
      end
   end

   // In-flight request, timeout timer, response and statistics registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         inWrite_q    <= 1'b0;
         inAddr_q     <= '0;
         inData_q     <= '0;
         timer_q      <= '0;
         respValid_q  <= 1'b0;
         respError_q  <= 1'b0;
         respData_q   <= '0;
         timeoutErr_q <= 1'b0;
         hitCount_q   <= '0;
         missCount_q  <= '0;
      end else begin
         respValid_q <= 1'b0;
         if (pop) begin
            inWrite_q <= fifoWrite_q[rdPtr_q];
            inAddr_q  <= fifoAddr_q[rdPtr_q];
            inData_q  <= fifoData_q[rdPtr_q];
         end
         if (state_q == ISSUE) begin
            timer_q <= '0;
         end else if (state_q == WAIT && !L1_cache_ready) begin
            timer_q <= timerInc;
         end
         if (completeNow) begin
            respValid_q <= 1'b1;
            respError_q <= 1'b0;
            respData_q  <= inWrite_q ? '0 : cache_L1_read_data;
         end else if (timeoutNow) begin
            respValid_q  <= 1'b1;
            respError_q  <= 1'b1;
            respData_q   <= '0;
            timeoutErr_q <= 1'b1;
         end
         if (state_q == WAIT && L1_cache_hit && hitCount_q != 16'hFFFF) begin
            hitCount_q <= hitCount_q + 16'd1;
         end
         if (state_q == WAIT && L1_cache_miss && missCount_q != 16'hFFFF) begin
            missCount_q <= missCount_q + 16'd1;
         end
      end
   end

   assign proc_req_ready          = ready_q;
   assign cache_L1_memory_address = inAddr_q;
   assign cache_write_data        = inData_q;
   assign proc_resp_valid         = respValid_q;
   assign proc_resp_data          = respData_q;
   assign proc_resp_error         = respError_q;
   assign timeout_error           = timeoutErr_q;
   assign hit_count               = hitCount_q;
   assign miss_count              = missCount_q;

endmodule

// File: tb/tb_cache_request_queue.sv
// Self-checking bench for cache_request_queue: directed transaction table, reset and
// fill corner cases, randomized traffic against a queue-based model, counter saturation.
module tb_cache_request_queue;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, reqValid, reqWrite, reqReady, readReq, writeReq;
   logic [31:0] reqAddr, reqData, l1Addr, l1WData, l1RData, respData;
   logic        l1Ready, l1Hit, l1Miss, respValid, respError, tmoError;
   logic [15:0] hitCount, missCount;

   logic        sReset, sValid, sReady, sRead, sWrite, sL1Ready, sHit, sMiss;
   logic        sRespValid, sRespError, sTmo;
   logic [31:0] sAddr, sL1Addr, sL1WData, sL1RData, sRespData;
   logic [15:0] sHitCount, sMissCount;

   cache_request_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .QUEUE_DEPTH(DEPTH),
                         .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk(clk), .reset(reset),
      .proc_req_valid(reqValid), .proc_req_write(reqWrite),
      .proc_req_address(reqAddr), .proc_req_data(reqData), .proc_req_ready(reqReady),
      .cache_read_request(readReq), .cache_write_request(writeReq),
      .cache_L1_memory_address(l1Addr), .cache_write_data(l1WData),
      .L1_cache_ready(l1Ready), .L1_cache_hit(l1Hit), .L1_cache_miss(l1Miss),
      .cache_L1_read_data(l1RData),
      .proc_resp_valid(respValid), .proc_resp_data(respData), .proc_resp_error(respError),
      .timeout_error(tmoError), .hit_count(hitCount), .miss_count(missCount));

   cache_request_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .QUEUE_DEPTH(2),
                         .TIMEOUT_CYCLES(70000)) u_sat (
      .clk(clk), .reset(sReset),
      .proc_req_valid(sValid), .proc_req_write(1'b0),
      .proc_req_address(sAddr), .proc_req_data(32'h0), .proc_req_ready(sReady),
      .cache_read_request(sRead), .cache_write_request(sWrite),
      .cache_L1_memory_address(sL1Addr), .cache_write_data(sL1WData),
      .L1_cache_ready(sL1Ready), .L1_cache_hit(sHit), .L1_cache_miss(sMiss),
      .cache_L1_read_data(sL1RData),
      .proc_resp_valid(sRespValid), .proc_resp_data(sRespData), .proc_resp_error(sRespError),
      .timeout_error(sTmo), .hit_count(sHitCount), .miss_count(sMissCount));

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
      logic        hitOnDone;
      logic        missOnDone;
      logic        readyInIssue;
      logic [31:0] l1Data;
      logic [31:0] expData;
      logic        expErr;
      logic [15:0] expHits;
      logic [15:0] expMisses;
      logic        expTimeout;
   } vec_t;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   int   testsRun = 0;
   int   testsFailed = 0;
   int   heldOff = 0;
   bit   sawFull = 0;
   req_t expQ[$];

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"}, reqReady, 1);
      checkOutput({tag, "_pulses"}, {readReq, writeReq}, 0);
      checkOutput({tag, "_addr"}, l1Addr, 0);
      checkOutput({tag, "_wdata"}, l1WData, 0);
      checkOutput({tag, "_respValid"}, respValid, 0);
      checkOutput({tag, "_respData"}, respData, 0);
      checkOutput({tag, "_respError"}, respError, 0);
      checkOutput({tag, "_timeoutError"}, tmoError, 0);
      checkOutput({tag, "_hits"}, hitCount, 0);
      checkOutput({tag, "_misses"}, missCount, 0);
   endtask

   task automatic doReset();
      reset = 1'b0; reqValid = 1'b0;
      l1Ready = 1'b0; l1Hit = 1'b0; l1Miss = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // One complete transaction from an idle, empty queue; starts and ends on a negedge.
   task automatic applyStimulus(input vec_t v);
      int limit;
      limit = (v.delay == 0) ? TMO : v.delay;
      reqValid = 1'b1; reqWrite = v.write; reqAddr = v.addr; reqData = v.wdata;
      @(negedge clk);
      reqValid = 1'b0;
      checkOutput("issueTooEarly", {readReq, writeReq}, 0);
      @(negedge clk);
      checkOutput("readPulse", readReq, !v.write);
      checkOutput("writePulse", writeReq, v.write);
      checkOutput("issueAddr", l1Addr, v.addr);
      checkOutput("issueWData", l1WData, v.wdata);
      l1Ready = v.readyInIssue; l1Hit = v.readyInIssue; l1Miss = v.readyInIssue;
      l1RData = 32'hFFFF_0000;
      for (int w = 1; w <= limit; w++) begin
         @(negedge clk);
         checkOutput("respTooEarly", respValid, 0);
         checkOutput("pulseInWait", {readReq, writeReq}, 0);
         checkOutput("addrHeld", l1Addr, v.addr);
         l1Ready = (w == v.delay);
         l1Hit   = (w == v.delay) && v.hitOnDone;
         l1Miss  = (w == v.delay) && v.missOnDone;
         l1RData = (w == v.delay) ? v.l1Data : 32'h0BAD_0BAD;
      end
      @(negedge clk);
      l1Ready = 1'b0; l1Hit = 1'b0; l1Miss = 1'b0;
      checkOutput("respValid", respValid, 1);
      checkOutput("respData", respData, v.expData);
      checkOutput("respError", respError, v.expErr);
      checkOutput("hitCount", hitCount, v.expHits);
      checkOutput("missCount", missCount, v.expMisses);
      checkOutput("timeoutError", tmoError, v.expTimeout);
      @(negedge clk);
      checkOutput("respSinglePulse", respValid, 0);
   endtask

   // Randomized traffic checked against a queue of accepted requests and an L1 responder
   // whose chosen completion delay alone decides every response.
   task automatic runTraffic(input int genCycles, input int reqPct, input int maxDelay);
      int          cyc = 0, accCount = 0, issueCount = 0, waitIdx = 0, delay = 0;
      int          lastIssue = -100, hitExp = 0, missExp = 0;
      bit          inIssue = 0, holding = 0, expectResp = 0, expErr = 0, tmoExp = 0;
      bit          curWrite = 0;
      logic [31:0] expData = 0, r;
      req_t        cur, hd;
      expQ.delete();
      forever begin
         @(negedge clk);
         if (readReq || writeReq) begin
            checkOutput("trafficIssueBusy", (waitIdx != 0) || inIssue, 0);
            checkOutput("trafficIssueSpacing", (cyc - lastIssue) >= 3, 1);
            checkOutput("trafficOneHot", readReq && writeReq, 0);
            if (expQ.size() == 0) begin
               checkOutput("trafficIssueFromEmpty", 1, 0);
            end else begin
               hd = expQ.pop_front();
               checkOutput("trafficIssueType", writeReq, hd.write);
               checkOutput("trafficIssueAddr", l1Addr, hd.addr);
               checkOutput("trafficIssueData", l1WData, hd.data);
               curWrite = hd.write;
            end
            issueCount++; lastIssue = cyc; inIssue = 1;
            delay = $urandom_range(1, maxDelay);
         end
         checkOutput("trafficRespValid", respValid, expectResp);
         if (expectResp) begin
            checkOutput("trafficRespData", respData, expData);
            checkOutput("trafficRespError", respError, expErr);
         end
         checkOutput("trafficReady", reqReady, (accCount - issueCount) < DEPTH);
         checkOutput("trafficHits", hitCount, hitExp);
         checkOutput("trafficMisses", missCount, missExp);
         checkOutput("trafficTimeoutFlag", tmoError, tmoExp);
         if (accCount - issueCount == DEPTH) sawFull = 1;
         expectResp = 0;
         if (cyc >= genCycles && !holding && expQ.size() == 0 && waitIdx == 0 && !inIssue)
            break;
         if (cyc >= genCycles + 600) begin
            checkOutput("trafficDrainBound", 1, 0);
            break;
         end
         r = $urandom;
         if (inIssue) begin
            l1Ready = r[0]; l1Hit = r[1]; l1Miss = r[2]; l1RData = $urandom;
            inIssue = 0; waitIdx = 1;
         end else if (waitIdx > 0) begin
            l1Ready = (waitIdx == delay); l1Hit = r[1]; l1Miss = r[2]; l1RData = $urandom;
            hitExp += int'(r[1]); missExp += int'(r[2]);
            if (l1Ready) begin
               expectResp = 1; expErr = 0; expData = curWrite ? 32'h0 : l1RData; waitIdx = 0;
            end else if (waitIdx == TMO) begin
               expectResp = 1; expErr = 1; expData = 32'h0; tmoExp = 1; waitIdx = 0;
            end else begin
               waitIdx++;
            end
         end else begin
            l1Ready = 1'b0; l1Hit = 1'b0; l1Miss = 1'b0;
         end
         if (!holding && cyc < genCycles && $urandom_range(0, 99) < reqPct) begin
            cur.write = 1'($urandom_range(0, 1)); cur.addr = $urandom; cur.data = $urandom;
            holding = 1;
         end
         reqValid = holding; reqWrite = cur.write; reqAddr = cur.addr; reqData = cur.data;
         if (holding && reqReady) begin
            expQ.push_back(cur); accCount++; holding = 0;
         end else if (holding) begin
            heldOff++;
         end
         cyc++;
      end
      reqValid = 1'b0; l1Ready = 1'b0; l1Hit = 1'b0; l1Miss = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: time limit reached before the bench completed");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int   pulses, resps;
      bit   found;
      vecs[0] = '{write: 0, addr: 32'h40, wdata: 32'h0, delay: 3, hitOnDone: 1, missOnDone: 0,
                  readyInIssue: 0, l1Data: 32'hDEADBEEF, expData: 32'hDEADBEEF, expErr: 0,
                  expHits: 1, expMisses: 0, expTimeout: 0};
      vecs[1] = '{write: 1, addr: 32'h80, wdata: 32'h12345678, delay: 2, hitOnDone: 0,
                  missOnDone: 1, readyInIssue: 0, l1Data: 32'hAAAA5555, expData: 32'h0,
                  expErr: 0, expHits: 1, expMisses: 1, expTimeout: 0};
      vecs[2] = '{write: 0, addr: 32'h1000, wdata: 32'h0, delay: TMO, hitOnDone: 1,
                  missOnDone: 1, readyInIssue: 1, l1Data: 32'hCAFEF00D, expData: 32'hCAFEF00D,
                  expErr: 0, expHits: 2, expMisses: 2, expTimeout: 0};
      vecs[3] = '{write: 0, addr: 32'h44, wdata: 32'h0, delay: 1, hitOnDone: 0, missOnDone: 0,
                  readyInIssue: 1, l1Data: 32'h1, expData: 32'h1, expErr: 0,
                  expHits: 2, expMisses: 2, expTimeout: 0};
      vecs[4] = '{write: 0, addr: 32'h2000, wdata: 32'h0, delay: 0, hitOnDone: 0,
                  missOnDone: 0, readyInIssue: 0, l1Data: 32'h0, expData: 32'h0, expErr: 1,
                  expHits: 2, expMisses: 2, expTimeout: 1};
      vecs[5] = '{write: 1, addr: 32'h3000, wdata: 32'h55AA55AA, delay: 5, hitOnDone: 1,
                  missOnDone: 0, readyInIssue: 0, l1Data: 32'h77777777, expData: 32'h0,
                  expErr: 0, expHits: 3, expMisses: 2, expTimeout: 1};

      reset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
      l1Ready = 1'b0; l1Hit = 1'b0; l1Miss = 1'b0; l1RData = '0;
      sReset = 1'b0; sValid = 1'b0; sAddr = '0; sL1Ready = 1'b0; sHit = 1'b0; sMiss = 1'b0;
      sL1RData = '0;

      fork
         begin
            @(negedge clk); @(negedge clk);
            reset = 1'b1;
            checkResetOutputs("init");
            for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

            // Reset while one request waits on L1 and two more are queued.
            for (int i = 0; i < 3; i++) begin
               reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h500 + 32'(i * 4); reqData = '0;
               @(negedge clk);
            end
            reqValid = 1'b0;
            @(negedge clk); @(negedge clk);
            reset = 1'b0; reqValid = 1'b1; reqAddr = 32'h999;
            @(negedge clk);
            reset = 1'b1; reqValid = 1'b0;
            checkResetOutputs("midWaitReset");
            pulses = 0; resps = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               pulses += int'(readReq) + int'(writeReq);
               resps  += int'(respValid);
            end
            checkOutput("noIssueAfterReset", pulses, 0);
            checkOutput("noRespAfterReset", resps, 0);

            doReset();
            runTraffic(60, 100, 12);
            checkOutput("fifoReachedFull", sawFull, 1);
            checkOutput("requestHeldOff", heldOff > 0, 1);

            doReset();
            runTraffic(1500, 40, 10);
         end
         begin
            @(negedge clk); @(negedge clk);
            sReset = 1'b1; sValid = 1'b1; sAddr = 32'h7000;
            @(negedge clk);
            sValid = 1'b0;
            found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
               @(negedge clk);
               found = sRead;
            end
            checkOutput("satIssue", found, 1);
            if (found) begin
               sHit = 1'b1; sMiss = 1'b1;
               for (int n = 0; n <= 65540; n++) begin
                  @(negedge clk);
                  if (n == 0) checkOutput("satIssueIgnored", sHitCount, 0);
                  if (n == 65534) checkOutput("satHitFFFE", sHitCount, 16'hFFFE);
                  if (n == 65535) checkOutput("satHitFFFF", sHitCount, 16'hFFFF);
                  if (n == 65540) begin
                     checkOutput("satHitHeld", sHitCount, 16'hFFFF);
                     checkOutput("satMissHeld", sMissCount, 16'hFFFF);
                     checkOutput("satNoResp", sRespValid, 0);
                     sL1Ready = 1'b1; sL1RData = 32'h600DF00D;
                  end
               end
               @(negedge clk);
               sL1Ready = 1'b0; sHit = 1'b0; sMiss = 1'b0;
               checkOutput("satRespValid", sRespValid, 1);
               checkOutput("satRespData", sRespData, 32'h600DF00D);
               checkOutput("satHitFinal", sHitCount, 16'hFFFF);
            end
         end
      join

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cache_request_queue.md
# cache_request_queue

Processor-side request front end that sits directly upstream of the multi-level cache top level. It buffers processor read/write requests in a small FIFO and issues them one at a time on the L1 request interface (`cache_read_request` / `cache_write_request`, `cache_L1_memory_address`, `cache_write_data`). It then waits for L1 completion and returns a response to the processor. It also enforces a completion timeout and keeps saturating L1 hit/miss counters.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, request address width (matches cache_config)
- DATA_WIDTH, 32, request/response data width (matches cache_config)
- QUEUE_DEPTH, 4, FIFO entries; power of two, at least 2
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before a request is abandoned; at least 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- proc_req_valid  in  1  processor request present
- proc_req_write  in  1  1 = write, 0 = read
- proc_req_address  in  ADDRESS_WIDTH  request address
- proc_req_data  in  DATA_WIDTH  write data (ignored for reads)
- proc_req_ready  out  1  FIFO can accept
- cache_read_request  out  1  one-cycle read issue pulse to L1
- cache_write_request  out  1  one-cycle write issue pulse to L1
- cache_L1_memory_address  out  ADDRESS_WIDTH  address of in-flight request
- cache_write_data  out  DATA_WIDTH  write data of in-flight request
- L1_cache_ready  in  1  L1 completion pulse
- L1_cache_hit  in  1  L1 hit indication
- L1_cache_miss  in  1  L1 miss indication
- cache_L1_read_data  in  DATA_WIDTH  L1 read data, valid with L1_cache_ready
- proc_resp_valid  out  1  one-cycle response pulse
- proc_resp_data  out  DATA_WIDTH  read data; 0 for writes and errors
- proc_resp_error  out  1  response produced by timeout
- timeout_error  out  1  sticky timeout flag
- hit_count  out  16  saturating L1 hit count
- miss_count  out  16  saturating L1 miss count

## Operation
- The one clock is `clk`. `reset` is synchronous and active-low: when `reset` is 0 at a rising edge, every register is cleared.
- FIFO:
  - Enqueue when proc_req_valid && proc_req_ready at an edge. Each entry stores {write, address, data}.
  - proc_req_ready is registered and equals (count < QUEUE_DEPTH) for the following cycle.
  - Read/write pointers wrap modulo QUEUE_DEPTH.
  - A pop and an enqueue in the same edge leave count unchanged.
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE: if the FIFO is non-empty, pop the head into the in-flight register and go to ISSUE.
  - ISSUE: assert cache_read_request or cache_write_request (per the entry) for exactly this cycle. Clear the timeout counter and go to WAIT. L1_cache_ready, L1_cache_hit and L1_cache_miss are ignored in ISSUE.
  - WAIT:
    - cache_L1_memory_address and cache_write_data hold the in-flight values.
    - Each cycle, L1_cache_hit increments hit_count and L1_cache_miss increments miss_count. Both counters saturate at 0xFFFF; if hit and miss are both high, both increment.
    - If L1_cache_ready=1: capture cache_L1_read_data (or 0 for a write) into proc_resp_data, set proc_resp_valid for the next cycle with proc_resp_error=0, and go to IDLE.
    - Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES, set timeout_error, and set proc_resp_valid with proc_resp_error=1 and proc_resp_data=0 for the next cycle, then go to IDLE.
    - If L1_cache_ready and the timeout boundary coincide, completion wins.
- The timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and never wraps.
- timeout_error clears only on reset.

## Timing
- Reset values:
  - proc_req_ready = 1 (registered, after reset).
  - All other outputs = 0: request pulses, address, write data, proc_resp_*, timeout_error, hit_count, miss_count.
  - FSM = IDLE, FIFO empty.
- Reset mid-operation: the FIFO is emptied and the in-flight request is abandoned without a response. All outputs take their reset values in the cycle after the reset edge. A request presented while reset=0 is not enqueued.
- Latency:
  - A request enqueued at edge k into an empty, IDLE block pops at edge k+1. The issue pulse is high during cycle k+2, and the block is in WAIT from cycle k+3.
  - L1_cache_ready sampled at edge m gives proc_resp_valid high during cycle m+1. The next queued request issues during cycle m+2.
- Throughput: one request in flight at a time. Back-to-back issue pulses are at least 3 cycles apart.
- Full FIFO: proc_req_ready is 0; a valid request is held off, never dropped or overwritten.
- proc_resp_valid is never high in two consecutive cycles.

## Test plan
- Single read: enqueue read at addr 0x40; L1_cache_ready=1 and L1_cache_hit=1 three cycles after the issue pulse, with read data 0xDEADBEEF -> one cache_read_request pulse with address 0x40; proc_resp_valid for one cycle with data 0xDEADBEEF and error 0; hit_count=1.
- Fill and drain: enqueue 5 requests back-to-back with QUEUE_DEPTH=4, L1 stalled -> proc_req_ready drops after the 4th accept, the 5th is held. Releasing completions -> all 5 issued in order with the correct write/read type and addresses.
- Write: enqueue write 0x80 / 0x12345678; L1 completes with a miss -> one cache_write_request pulse with data 0x12345678; response data 0; miss_count=1.
- Timeout: TIMEOUT_CYCLES=8, L1 never ready -> response with error=1 exactly 8 WAIT cycles after the issue; timeout_error stays 1; the next queued request still issues.
- Boundary: L1_cache_ready arrives on the 8th WAIT cycle -> normal response, error=0, timeout_error stays 0. L1_cache_ready during ISSUE is ignored.
- Reset mid-WAIT with 2 entries queued -> no response, all outputs zero next cycle, proc_req_ready=1, no issue pulses afterwards. Preload hit_count to saturation (65536 hits) -> count remains 0xFFFF.
